rd_fsm: RTL and testbench

RD_FSM -- requirements
Module: rd_fsm

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/rd_fsm.sv | 140 ++++++++++++++
 tb/tb_rd_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared types for the AXI-Lite slave channel FSMs.
//   resp_t     : AXI read/write response codes, shared by rd_fsm and wr_fsm.
//   rd_state_t : state encoding of the read-channel FSM (rd_fsm).
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    MEM_WAIT     = 2'b01,
    DATA_CAPTURE = 2'b10,
    RESPONSE     = 2'b11
  } rd_state_t;

endpackage

// File: rtl/rd_fsm.sv
// -----------------------------------------------------------------------------
// rd_fsm
// AXI-Lite read-channel slave in front of a synchronous-read memory.
// One read is outstanding at a time: AR handshake -> one-cycle rd_en strobe ->
// memory word captured -> R beat held until the master accepts it.
// Out-of-range addresses never strobe the memory and answer SLVERR with zero data.
//
// Ports
//   CLK      in   clock, all logic on the rising edge
//   RSTn     in   synchronous active-low reset
//   ARADDR   in   read word address            [ADDR_WIDTH]
//   ARVALID  in   read address valid
//   ARREADY  out  read address ready           (registered)
//   RDATA    out  read data                    [DATA_WIDTH] (registered)
//   RRESP    out  read response OKAY/SLVERR    [2] (registered)
//   RVALID   out  read data valid              (registered)
//   RREADY   in   master ready for read data
//   rd_en    out  memory read strobe           (registered)
//   rd_addr  out  memory read address          [ADDR_WIDTH] (registered)
//   rd_data  in   memory read data, valid the cycle after the rd_en cycle
// -----------------------------------------------------------------------------
module rd_fsm
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  // One extra bit so that MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = MEM_DEPTH[ADDR_WIDTH:0];

  rd_state_t             state_r;
  logic                  err_r;       // current read targets an illegal address
  logic [DATA_WIDTH-1:0] cap_data_r;  // memory word captured while it is valid
  resp_t                 cap_resp_r;

  logic ar_hs_s;
  logic addr_ok_s;

  assign ar_hs_s   = ARVALID & ARREADY;
  assign addr_ok_s = ({1'b0, ARADDR} < DEPTH_LIMIT);

  // Read-channel FSM and its registered outputs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r    <= IDLE;
      ARREADY    <= 1'b1;
      RVALID     <= 1'b0;
      RRESP      <= OKAY;
      RDATA      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      err_r      <= 1'b0;
      cap_data_r <= '0;
      cap_resp_r <= OKAY;
    end else begin
      case (state_r)
        IDLE: begin
          if (ar_hs_s) begin
            ARREADY <= 1'b0;
            state_r <= MEM_WAIT;
            if (addr_ok_s) begin
              rd_addr <= ARADDR;
              rd_en   <= 1'b1;
              err_r   <= 1'b0;
            end else begin
              rd_en   <= 1'b0;
              err_r   <= 1'b1;
            end
          end else begin
            ARREADY <= 1'b1;
          end
        end

        MEM_WAIT: begin
          // Strobe is exactly one cycle wide.
          rd_en   <= 1'b0;
          state_r <= DATA_CAPTURE;
        end

        DATA_CAPTURE: begin
          // rd_data is only guaranteed this cycle, so grab it into a holding
          // register; the R beat is presented from it on the following edge.
          if (err_r) begin
            cap_data_r <= '0;
            cap_resp_r <= SLVERR;
          end else begin
            cap_data_r <= rd_data;
            cap_resp_r <= OKAY;
          end
          state_r <= RESPONSE;
        end

        RESPONSE: begin
          if (!RVALID) begin
            RVALID <= 1'b1;
            RDATA  <= cap_data_r;
            RRESP  <= cap_resp_r;
          end else if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            err_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            // Master not ready: beat stays frozen.
            RVALID <= 1'b1;
          end
        end

        default: begin
          state_r    <= IDLE;
          ARREADY    <= 1'b1;
          RVALID     <= 1'b0;
          RRESP      <= OKAY;
          RDATA      <= '0;
          rd_en      <= 1'b0;
          rd_addr    <= '0;
          err_r      <= 1'b0;
          cap_data_r <= '0;
          cap_resp_r <= OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_fsm.sv
// -----------------------------------------------------------------------------
// tb_rd_fsm
// Self-checking bench for rd_fsm (MEM_DEPTH = 32 of a 64-word address space).
// A transaction-level model predicts the outputs every cycle from the AXI
// read rules; directed read sequences add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_rd_fsm;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_en_total = 0;
  logic [AW-1:0] last_rd_addr = '0;

  rd_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: data valid only in the cycle after the strobe cycle.
  always @(posedge CLK) begin
    rd_data <= (rd_en === 1'b1) ? mem[rd_addr] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit            model_on = 1'b0;
  bit            busy = 1'b0;
  bit            fresh = 1'b0;
  int            age = 0;
  logic          m_arready, m_rvalid, m_rd_en;
  logic [DW-1:0] m_rdata, exp_data;
  logic [1:0]    m_rresp, exp_resp;
  logic [AW-1:0] m_rd_addr;

  initial forever begin
    @(negedge CLK);
    if (rd_en === 1'b1) begin
      rd_en_total++;
      last_rd_addr = rd_addr;
    end
    if (model_on) begin
      chk("m_arready", ARREADY, m_arready);
      chk("m_rvalid", RVALID, m_rvalid);
      chk("m_rd_en", rd_en, m_rd_en);
      if (m_rd_en) chk("m_rd_addr", rd_addr, m_rd_addr);
      if (m_rvalid || fresh) begin
        chk("m_rdata", RDATA, m_rdata);
        chk("m_rresp", RRESP, m_rresp);
      end
    end
    // Predict outputs after the coming rising edge from the inputs now stable.
    if (RSTn !== 1'b1) begin
      model_on = 1'b1; fresh = 1'b1; busy = 1'b0; age = 0;
      m_arready = 1'b1; m_rvalid = 1'b0; m_rd_en = 1'b0;
      m_rdata = '0; m_rresp = 2'b00; m_rd_addr = '0;
    end else if (!busy) begin
      m_rd_en = 1'b0;
      if (ARVALID === 1'b1) begin
        busy = 1'b1; age = 0; m_arready = 1'b0;
        if (int'(ARADDR) < DEPTH) begin
          m_rd_en = 1'b1; m_rd_addr = ARADDR;
          exp_data = mem[ARADDR]; exp_resp = 2'b00;
        end else begin
          exp_data = '0; exp_resp = 2'b10;
        end
      end
    end else begin
      age++;
      m_rd_en = 1'b0;
      if (m_rvalid && RREADY === 1'b1) begin
        m_rvalid = 1'b0; m_arready = 1'b1; busy = 1'b0;
      end else if (age == 3) begin
        m_rvalid = 1'b1; m_rdata = exp_data; m_rresp = exp_resp; fresh = 1'b0;
      end
    end
  end

  // mode 0: ARVALID dropped after handshake; 1: held high; 2: held high with
  // ARADDR changing every cycle. hold = cycles RREADY stays low after RVALID.
  task automatic read_txn(input logic [AW-1:0] addr, input int hold, input int mode,
                          output int lat, output logic [DW-1:0] data,
                          output logic [1:0] resp, output int pulses, output bit stable);
    int e0;
    e0 = rd_en_total;
    lat = 0; stable = 1'b1;
    ARADDR = addr; ARVALID = 1'b1; RREADY = (hold == 0);
    @(posedge CLK); #1;
    if (mode == 0) ARVALID = 1'b0;
    while (RVALID !== 1'b1 && lat < 20) begin
      lat++;
      if (mode == 2) ARADDR = ARADDR + 6'd1;
      @(posedge CLK); #1;
    end
    data = RDATA; resp = RRESP;
    for (int i = 0; i < hold; i++) begin
      if (mode == 2) ARADDR = ARADDR + 6'd1;
      @(posedge CLK); #1;
      if (RVALID !== 1'b1 || RDATA !== data || RRESP !== resp) stable = 1'b0;
    end
    RREADY = 1'b1;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    pulses = rd_en_total - e0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, pulses, cnt;
    logic [DW-1:0] d;
    logic [1:0] r;
    bit st;
    logic [AW-1:0] a;

    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h3333_3333;
    mem[7] = 32'h7777_0007;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_arready", ARREADY, 1);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    RSTn = 1'b1;

    // Single read, RREADY already high.
    read_txn(6'd5, 0, 0, lat, d, r, pulses, st);
    chk("t1_latency", lat, 3);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", r, 2'b00);
    chk("t1_rd_en_pulses", pulses, 1);
    chk("t1_rd_addr", last_rd_addr, 5);
    chk("t1_rvalid_one_cycle", RVALID, 0);
    chk("t1_arready_back", ARREADY, 1);

    // Back-pressure: RREADY low for 4 cycles.
    read_txn(6'd5, 4, 0, lat, d, r, pulses, st);
    chk("t2_latency", lat, 3);
    chk("t2_stable", st, 1);
    chk("t2_rdata", d, 32'hDEADBEEF);
    chk("t2_rvalid_drop", RVALID, 0);
    chk("t2_arready_back", ARREADY, 1);

    // Out-of-range address, then a legal one.
    read_txn(6'd40, 0, 0, lat, d, r, pulses, st);
    chk("t3_err_rdata", d, 0);
    chk("t3_err_rresp", r, 2'b10);
    chk("t3_err_no_rd_en", pulses, 0);
    chk("t3_err_latency", lat, 3);
    read_txn(6'd3, 0, 0, lat, d, r, pulses, st);
    chk("t3_ok_rresp", r, 2'b00);
    chk("t3_ok_rdata", d, 32'h3333_3333);

    // ARVALID held with moving ARADDR during the whole transaction.
    read_txn(6'd7, 2, 2, lat, d, r, pulses, st);
    chk("t4_rd_en_pulses", pulses, 1);
    chk("t4_rd_addr", last_rd_addr, 7);
    chk("t4_rdata", d, 32'h7777_0007);
    chk("t4_stable", st, 1);

    // Reset while RVALID is high.
    ARADDR = 6'd9; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    cnt = 0;
    while (RVALID !== 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge CLK); #1;
    end
    chk("t5_rvalid_before_rst", RVALID, 1);
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    chk("t5_rvalid_after_rst", RVALID, 0);
    chk("t5_arready_after_rst", ARREADY, 1);
    chk("t5_rdata_after_rst", RDATA, 0);
    read_txn(6'd9, 0, 0, lat, d, r, pulses, st);
    chk("t5_new_read_rdata", d, mem[9]);
    chk("t5_new_read_rresp", r, 2'b00);
    chk("t5_new_read_latency", lat, 3);

    // Ten back-to-back reads, ARVALID and RREADY held high.
    for (int k = 0; k < 10; k++) begin
      a = 6'($urandom_range(0, DEPTH - 1));
      read_txn(a, 0, 1, lat, d, r, pulses, st);
      chk("t6_rdata", d, mem[a]);
      chk("t6_latency", lat, 3);
      chk("t6_pulses", pulses, 1);
    end

    repeat (2) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
